fetch_sequencer: RTL and testbench

//  Sequences instruction fetch between the PC logic and a multi-cycle instruction memory.

---
 rtl/fetch_sequencer.sv | 164 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: drives one-at-a-time instruction fetches over a req/gnt/rvalid
// memory handshake. Returned words and their PCs are buffered in a small FIFO
// for decode. A redirect flushes the FIFO and squashes any in-flight response.
`timescale 1ns/1ps
module fetch_sequencer #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     QDEPTH   = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            if_ready
);

    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_req_pc;
    logic [XLEN-1:0] r_mem_addr;
    logic            r_mem_req;
    logic            r_squash;

    logic [XLEN-1:0] r_q_instr [QDEPTH];
    logic [XLEN-1:0] r_q_pc    [QDEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    logic [XLEN-1:0] w_redir_pc;
    logic            w_pop;
    logic            w_push;
    logic [CW-1:0]   w_count_nxt;
    logic            w_space_now;
    logic            w_space_after;

    assign w_redir_pc    = redirect_pc & ~XLEN'(3);
    // A redirect drops any pop or push in the same cycle.
    assign w_pop         = (r_count != '0) && if_ready && !redirect_valid;
    assign w_push        = (r_state == S_WAIT) && mem_rvalid && !r_squash && !redirect_valid;
    assign w_count_nxt   = r_count + CW'(w_push) - CW'(w_pop);
    assign w_space_now   = r_count < CW'(QDEPTH);
    assign w_space_after = w_count_nxt < CW'(QDEPTH);

    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;
    assign if_valid = (r_count != '0);
    assign if_instr = r_q_instr[r_rptr];
    assign if_pc    = r_q_pc[r_rptr];

    // Fetch FSM: request issue, grant tracking, redirect/squash handling.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_mem_addr <= RESET_PC;
            r_mem_req  <= 1'b0;
            r_squash   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (redirect_valid) begin
                        r_fetch_pc <= w_redir_pc;
                        r_mem_addr <= w_redir_pc;
                        r_mem_req  <= 1'b1;
                        r_state    <= S_REQ;
                    end else if (w_space_now) begin
                        r_mem_addr <= r_fetch_pc;
                        r_mem_req  <= 1'b1;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    // mem_addr is never touched here, so it stays stable until grant
                    // even when a redirect retargets fetch_pc underneath it.
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_req_pc  <= r_mem_addr;
                        r_state   <= S_WAIT;
                        if (redirect_valid) begin
                            r_squash   <= 1'b1;
                            r_fetch_pc <= w_redir_pc;
                        end else if (!r_squash) begin
                            r_fetch_pc <= r_fetch_pc + XLEN'(4);
                        end
                    end else if (redirect_valid) begin
                        r_squash   <= 1'b1;
                        r_fetch_pc <= w_redir_pc;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        r_squash <= 1'b0;
                        if (redirect_valid) begin
                            r_fetch_pc <= w_redir_pc;
                            r_mem_addr <= w_redir_pc;
                            r_mem_req  <= 1'b1;
                            r_state    <= S_REQ;
                        end else if (w_space_after) begin
                            r_mem_addr <= r_fetch_pc;
                            r_mem_req  <= 1'b1;
                            r_state    <= S_REQ;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (redirect_valid) begin
                        r_squash   <= 1'b1;
                        r_fetch_pc <= w_redir_pc;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    // Instruction FIFO: push returned words, pop on decode handshake, flush on redirect.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                r_q_instr[i] <= '0;
                r_q_pc[i]    <= '0;
            end
        end else if (redirect_valid) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_q_instr[r_wptr] <= mem_rdata;
                r_q_pc[r_wptr]    <= r_req_pc;
                r_wptr            <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= w_count_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed tests for fetch_sequencer with a latency-
// configurable memory model and a transaction-level reference model.
`timescale 1ns/1ps
module tb_fetch_sequencer;

    localparam int unsigned QD = 2;

    logic        clock;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;

    fetch_sequencer #(.XLEN(32), .RESET_PC(32'h0), .QDEPTH(QD)) dut (
        .clock(clock), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    int n_tests = 0;
    int n_fail  = 0;

    // memory model state
    bit          pend;
    logic [31:0] pend_addr;
    int          pend_wait;
    int          resp_lat;
    int          gnt_hold;
    bit          last_req;
    logic [31:0] gnt_log[$];
    ent_t        clog[$];

    // reference model state
    ent_t        mq[$];
    bit          m_req, m_wait, m_squash;
    logic [31:0] m_addr, m_fpc, m_wait_pc;

    function automatic logic [31:0] f(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string why);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s at %0t", name, why, $time);
    endtask

    task automatic chk_pc(input string name, input int unsigned idx, input logic [31:0] exp_pc);
        if (idx >= clog.size()) fail_now(name, "consumed entry missing");
        else begin
            chk(name, clog[idx].pc, exp_pc);
            chk({name, "_instr"}, clog[idx].instr, f(exp_pc));
        end
    endtask

    task automatic chk_gnt(input string name, input int unsigned idx, input logic [31:0] exp_a);
        if (idx >= gnt_log.size()) fail_now(name, "granted request missing");
        else chk(name, gnt_log[idx], exp_a);
    endtask

    // One cycle: at the falling edge, account for the last rising edge and drive memory.
    task automatic tick();
        @(negedge clock);
        redirect_valid = 1'b0;
        if (reset) begin
            pend = 1'b0; last_req = 1'b0;
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hDEAD_BEEF;
            return;
        end
        if (mem_rvalid) pend = 1'b0;
        if (mem_gnt && last_req) begin
            pend = 1'b1; pend_addr = gnt_log[gnt_log.size()-1]; pend_wait = resp_lat;
        end
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hDEAD_BEEF;
        if (pend) begin
            if (pend_wait == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = f(pend_addr);
            end else pend_wait--;
        end
        mem_gnt = 1'b0;
        if (mem_req && !pend) begin
            if (gnt_hold > 0) gnt_hold--;
            else mem_gnt = 1'b1;
        end
        if (mem_gnt) gnt_log.push_back(mem_addr);
        last_req = mem_req;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1; if_ready = 1'b0; gnt_hold = 0; resp_lat = 0;
        tick(); tick();
        reset = 1'b0;
    endtask

    // Reference model: advances one transaction step per rising edge.
    initial forever begin
        @(posedge clock or posedge reset);
        if (reset) begin
            mq.delete();
            m_req = 1'b0; m_wait = 1'b0; m_squash = 1'b0;
            m_addr = 32'h0; m_fpc = 32'h0; m_wait_pc = 32'h0;
        end else begin
            logic [31:0] tgt;
            bit pop, push, issue;
            int old_n;
            ent_t e;
            if (if_valid && if_ready && !redirect_valid) begin
                e.pc = if_pc; e.instr = if_instr; clog.push_back(e);
            end
            tgt   = redirect_pc & ~32'h3;
            old_n = mq.size();
            pop   = (old_n != 0) && if_ready && !redirect_valid;
            push  = m_wait && mem_rvalid && !m_squash && !redirect_valid;
            if (redirect_valid) mq.delete();
            else begin
                if (pop) mq.delete(0);
                if (push) begin e.pc = m_wait_pc; e.instr = mem_rdata; mq.push_back(e); end
            end
            issue = 1'b0;
            if (m_req) begin
                if (mem_gnt) begin
                    m_req = 1'b0; m_wait = 1'b1; m_wait_pc = m_addr;
                    if (redirect_valid) begin m_squash = 1'b1; m_fpc = tgt; end
                    else if (!m_squash) m_fpc = m_fpc + 32'd4;
                end else if (redirect_valid) begin
                    m_squash = 1'b1; m_fpc = tgt;
                end
            end else if (m_wait) begin
                if (mem_rvalid) begin
                    m_wait = 1'b0; m_squash = 1'b0;
                    if (redirect_valid) m_fpc = tgt;
                    issue = redirect_valid || (mq.size() < QD);
                end else if (redirect_valid) begin
                    m_squash = 1'b1; m_fpc = tgt;
                end
            end else begin
                if (redirect_valid) m_fpc = tgt;
                issue = redirect_valid || (old_n < QD);
            end
            if (issue) begin m_req = 1'b1; m_addr = m_fpc; end
        end
    end

    // Compare process: every falling edge out of reset.
    initial forever begin
        @(negedge clock);
        if (!reset) begin
            chk("mem_req", 32'(mem_req), 32'(m_req));
            if (m_req) chk("mem_addr", mem_addr, m_addr);
            chk("if_valid", 32'(if_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("if_pc", if_pc, mq[0].pc);
                chk("if_instr", if_instr, mq[0].instr);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        bit saw8;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; if_ready = 1'b0;
        gnt_hold = 0; resp_lat = 0; pend = 1'b0; last_req = 1'b0;
        tick(); tick();
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_if_valid", 32'(if_valid), 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        reset = 1'b0;

        // 1: streaming with zero-wait memory
        if_ready = 1'b1;
        ticks(14);
        chk_gnt("t1_gnt0", 0, 32'h0);
        chk_gnt("t1_gnt1", 1, 32'h4);
        chk_gnt("t1_gnt2", 2, 32'h8);
        chk_pc("t1_pc0", 0, 32'h0);
        chk_pc("t1_pc1", 1, 32'h4);
        chk_pc("t1_pc2", 2, 32'h8);

        // 2: decode stall fills the queue, then drains in order
        if_ready = 1'b0;
        ticks(10);
        chk("t2_req_low", 32'(mem_req), 32'h0);
        chk("t2_valid", 32'(if_valid), 32'h1);
        clog.delete();
        if_ready = 1'b1;
        ticks(12);
        for (int unsigned k = 0; k < 4; k++) begin
            if (k + 1 >= clog.size()) fail_now("t2_order", "too few entries drained");
            else begin
                chk("t2_order", clog[k+1].pc, clog[k].pc + 32'd4);
                chk("t2_data", clog[k].instr, f(clog[k].pc));
            end
        end

        // 3: redirect while waiting on the response for 0x8
        do_reset();
        resp_lat = 2; if_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (mem_req && mem_gnt && mem_addr == 32'h8) found = 1'b1;
        end
        if (!found) fail_now("t3_wait", "no grant for 0x8");
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        clog.delete();
        ticks(20);
        saw8 = 1'b0;
        foreach (clog[k]) if (clog[k].pc == 32'h8) saw8 = 1'b1;
        chk("t3_no_0x8", 32'(saw8), 32'h0);
        chk_pc("t3_first", 0, 32'h100);
        chk_pc("t3_second", 1, 32'h104);

        // 4: redirect while request is held ungranted
        do_reset();
        gnt_hold = 3; if_ready = 1'b1;
        gnt_log.delete(); clog.delete();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (mem_req && !mem_gnt) found = 1'b1;
        end
        if (!found) fail_now("t4_req", "no held request");
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (mem_req) chk("t4_addr_hold", mem_addr, 32'h0);
            if (mem_gnt) found = 1'b1;
        end
        if (!found) fail_now("t4_gnt", "grant never given");
        ticks(12);
        chk_gnt("t4_gnt0", 0, 32'h0);
        chk_gnt("t4_gnt1", 1, 32'h200);
        chk_pc("t4_first", 0, 32'h200);

        // 5: redirect, rvalid and pop in the same cycle
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (mem_rvalid && if_valid) found = 1'b1;
        end
        if (!found) fail_now("t5_setup", "no rvalid with queued entry");
        if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
        gnt_log.delete(); clog.delete();
        tick();
        chk("t5_flushed", 32'(if_valid), 32'h0);
        ticks(12);
        chk_gnt("t5_gnt0", 0, 32'h300);
        chk_pc("t5_first", 0, 32'h300);

        // 6: unaligned redirect near the top of memory, wrap, then async reset in WAIT
        do_reset();
        if_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        gnt_log.delete(); clog.delete();
        ticks(12);
        chk_gnt("t6_gnt0", 0, 32'hFFFF_FFFC);
        chk_gnt("t6_gnt1", 1, 32'h0);
        chk_pc("t6_pc0", 0, 32'hFFFF_FFFC);
        chk_pc("t6_pc1", 1, 32'h0);
        resp_lat = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (mem_req && mem_gnt) found = 1'b1;
        end
        if (!found) fail_now("t6_wait", "no grant before reset");
        tick();
        #2 reset = 1'b1;
        #1;
        chk("t6_arst_req", 32'(mem_req), 32'h0);
        chk("t6_arst_addr", mem_addr, 32'h0);
        chk("t6_arst_valid", 32'(if_valid), 32'h0);
        chk("t6_arst_instr", if_instr, 32'h0);
        chk("t6_arst_pc", if_pc, 32'h0);
        tick(); tick();
        resp_lat = 0;
        gnt_log.delete(); clog.delete();
        reset = 1'b0;
        ticks(10);
        chk_gnt("t6_post_gnt0", 0, 32'h0);
        chk_pc("t6_post_pc0", 0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
